// File: rtl/obi_avalon_bridge_if.sv
// Bus bundles for obi_avalon_bridge: the OBI core side and the Avalon-MM memory side.
// Signal names keep the bridge-relative _i/_o suffixes so they read the same inside the bridge.
interface obi_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    core_req_i;
  logic                    core_gnt_o;
  logic [ADDR_WIDTH-1:0]   core_addr_i;
  logic                    core_we_i;
  logic [DATA_WIDTH/8-1:0] core_be_i;
  logic [DATA_WIDTH-1:0]   core_wdata_i;
  logic                    core_rvalid_o;
  logic [DATA_WIDTH-1:0]   core_rdata_o;
  logic                    core_err_o;

  modport master (
    output core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o
  );

  modport slave (
    input  core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o
  );
endinterface

interface avm_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    avm_read_o;
  logic                    avm_write_o;
  logic [ADDR_WIDTH-1:0]   avm_address_o;
  logic [DATA_WIDTH/8-1:0] avm_byteenable_o;
  logic [DATA_WIDTH-1:0]   avm_writedata_o;
  logic                    avm_waitrequest_i;
  logic                    avm_readdatavalid_i;
  logic [DATA_WIDTH-1:0]   avm_readdata_i;
  logic [1:0]              avm_response_i;
  logic                    avm_writeresponsevalid_i;

  modport master (
    output avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o, avm_writedata_o,
    input  avm_waitrequest_i, avm_readdatavalid_i, avm_readdata_i, avm_response_i,
           avm_writeresponsevalid_i
  );

  modport slave (
    input  avm_read_o, avm_write_o, avm_address_o, avm_byteenable_o, avm_writedata_o,
    output avm_waitrequest_i, avm_readdatavalid_i, avm_readdata_i, avm_response_i,
           avm_writeresponsevalid_i
  );
endinterface

// File: rtl/obi_avalon_bridge.sv
// OBI-to-Avalon-MM bridge with an in-order read/write tracking FIFO and registered responses.
// Define OBI_AVL_WRESP_EN to complete writes on avm_writeresponsevalid_i instead of internally.
module obi_avalon_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  obi_bus_if.slave         obi,
  avm_bus_if.master        avm,
  output logic [4:0]       outstanding_o,
  output logic             proto_err_o
);

  localparam int                PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [4:0]        MAX_CNT  = 5'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  logic [4:0]                 count_q, count_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic                       rvalid_q, rvalid_d;
  logic                       err_q, err_d;
  logic                       proto_q, proto_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;

  logic full, empty, headIsWrite, grant;
  logic rdCompl, wrCompl, wrErr, protoEvent, compl;
  logic unusedWresp;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign avm.avm_read_o       = obi.core_req_i & ~obi.core_we_i & ~full;
  assign avm.avm_write_o      = obi.core_req_i &  obi.core_we_i & ~full;
  assign avm.avm_address_o    = obi.core_addr_i;
  assign avm.avm_byteenable_o = obi.core_be_i;
  assign avm.avm_writedata_o  = obi.core_wdata_i;

  assign obi.core_gnt_o    = grant;
  assign obi.core_rvalid_o = rvalid_q;
  assign obi.core_rdata_o  = rdata_q;
  assign obi.core_err_o    = err_q;
  assign outstanding_o     = count_q;
  assign proto_err_o       = proto_q;

  always_comb begin
    full        = (count_q == MAX_CNT);
    empty       = (count_q == 5'd0);
    headIsWrite = fifo_q[rptr_q];
    grant       = obi.core_req_i & ~full & ~avm.avm_waitrequest_i;
    rdCompl     = avm.avm_readdatavalid_i & ~empty & ~headIsWrite;
`ifdef OBI_AVL_WRESP_EN
    unusedWresp = 1'b0;
    wrCompl     = avm.avm_writeresponsevalid_i & ~empty & headIsWrite;
    wrErr       = |avm.avm_response_i;
    protoEvent  = (avm.avm_readdatavalid_i & (empty | headIsWrite)) |
                  (avm.avm_writeresponsevalid_i & (empty | ~headIsWrite));
`else
    // A write at the head retires on its own; the write-response strobe has no meaning here.
    unusedWresp = avm.avm_writeresponsevalid_i;
    wrCompl     = ~empty & headIsWrite;
    wrErr       = 1'b0;
    protoEvent  = avm.avm_readdatavalid_i & (empty | headIsWrite);
`endif
    compl = rdCompl | wrCompl;

    fifo_d = fifo_q;
    if (grant) fifo_d[wptr_q] = obi.core_we_i;
    wptr_d = grant ? nextPtr(wptr_q) : wptr_q;
    rptr_d = compl ? nextPtr(rptr_q) : rptr_q;

    unique case ({grant, compl})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    rvalid_d = compl;
    rdata_d  = rdCompl ? avm.avm_readdata_i : '0;
    err_d    = rdCompl ? |avm.avm_response_i : (wrCompl & wrErr);
    proto_d  = proto_q | protoEvent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fifo_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      proto_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fifo_q   <= fifo_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      proto_q  <= proto_d;
    end
  end

endmodule

// File: tb/tb_obi_avalon_bridge.sv
// Testbench for obi_avalon_bridge: directed scenarios then random traffic, all checked each
// cycle against a queue-based model of outstanding transfers.
module tb_obi_avalon_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] outstanding;
  logic       protoErr;

  always #5 clk = ~clk;

  obi_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) obi ();
  avm_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) avm ();

  obi_avalon_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .obi(obi), .avm(avm),
    .outstanding_o(outstanding), .proto_err_o(protoErr)
  );

  logic          sRst, sReq, sWe, sWait, sRdv, sWrv;
  logic [AW-1:0] sAddr;
  logic [3:0]    sBe;
  logic [DW-1:0] sWdata, sRdata;
  logic [1:0]    sResp;

  // Model state: queue of accepted-but-unfinished transfers (1 = write) and the next response.
  bit            mq[$];
  logic          expRvalid, expErr, expProto;
  logic [DW-1:0] expRdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sReq = 1'b0; sWe = 1'b0; sWait = 1'b0; sRdv = 1'b0; sWrv = 1'b0;
    sResp = 2'b00; sRdata = $urandom;
  endtask

  task automatic driveInputs();
    rst                          = sRst;
    obi.core_req_i               = sReq;
    obi.core_we_i                = sWe;
    obi.core_addr_i              = sAddr;
    obi.core_be_i                = sBe;
    obi.core_wdata_i             = sWdata;
    avm.avm_waitrequest_i        = sWait;
    avm.avm_readdatavalid_i      = sRdv;
    avm.avm_writeresponsevalid_i = sWrv;
    avm.avm_readdata_i           = sRdata;
    avm.avm_response_i           = sResp;
  endtask

  task automatic modelReset();
    mq.delete();
    expRvalid = 1'b0; expErr = 1'b0; expProto = 1'b0; expRdata = '0;
  endtask

  task automatic checkOutput();
    bit full;
    full = (mq.size() == MAXO);
    check("gnt",         obi.core_gnt_o,        sReq && !full && !sWait);
    check("avm_read",    avm.avm_read_o,        sReq && !sWe && !full);
    check("avm_write",   avm.avm_write_o,       sReq && sWe && !full);
    check("avm_address", avm.avm_address_o,     sAddr);
    check("avm_be",      avm.avm_byteenable_o,  sBe);
    check("avm_wdata",   avm.avm_writedata_o,   sWdata);
    check("outstanding", outstanding,           mq.size());
    check("rvalid",      obi.core_rvalid_o,     expRvalid);
    check("proto_err",   protoErr,              expProto);
    if (expRvalid || sRst) begin
      check("rdata", obi.core_rdata_o, expRdata);
      check("err",   obi.core_err_o,   expErr);
    end
  endtask

  task automatic modelStep();
    bit g, done, wrvCounts;
    g    = sReq && (mq.size() != MAXO) && !sWait;
    done = 1'b0;
`ifdef OBI_AVL_WRESP_EN
    wrvCounts = sWrv;
`else
    wrvCounts = 1'b0;
`endif
    expRvalid = 1'b0; expRdata = '0; expErr = 1'b0;
    if (mq.size() == 0) begin
      if (sRdv || wrvCounts) expProto = 1'b1;
    end else if (mq[0] == 1'b0) begin
      if (sRdv) begin done = 1'b1; expRdata = sRdata; expErr = |sResp; end
      if (wrvCounts) expProto = 1'b1;
    end else begin
      if (sRdv) expProto = 1'b1;
`ifdef OBI_AVL_WRESP_EN
      if (sWrv) begin done = 1'b1; expErr = |sResp; end
`else
      done = 1'b1;
`endif
    end
    expRvalid = done;
    if (done) void'(mq.pop_front());
    if (g) mq.push_back(sWe);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    driveInputs();
    if (sRst) modelReset();
    #1;
    checkOutput();
    if (!sRst) modelStep();
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && mq.size() > 0; n++) begin
      idle();
      sRdv = (mq[0] == 1'b0);
`ifdef OBI_AVL_WRESP_EN
      sWrv = (mq[0] == 1'b1);
`endif
      applyStimulus();
    end
    idle();
    applyStimulus();
  endtask

  task automatic pulseReset();
    idle(); sRst = 1'b1; applyStimulus(); applyStimulus();
    sRst = 1'b0; applyStimulus();
  endtask

  initial begin
    sRst = 1'b1; sAddr = '0; sBe = 4'hF; sWdata = '0;
    idle();
    modelReset();
    driveInputs();
    applyStimulus();
    applyStimulus();
    sRst = 1'b0;
    applyStimulus();

    // Single read returning 0xDEADBEEF three cycles after the grant.
    sReq = 1'b1; sWe = 1'b0; sAddr = 32'h100; applyStimulus();
    idle(); applyStimulus(); applyStimulus();
    sRdv = 1'b1; sRdata = 32'hDEADBEEF; applyStimulus();
    idle(); applyStimulus();
    check("single_rvalid", obi.core_rvalid_o, 1'b1);
    check("single_rdata",  obi.core_rdata_o,  32'hDEADBEEF);
    check("single_err",    obi.core_err_o,    1'b0);

    // Fill to MAX_OUTSTANDING; a completion while full still blocks the grant that cycle.
    for (int i = 0; i < 5; i++) begin
      idle(); sReq = 1'b1; sAddr = 32'h200 + 32'(i * 4); applyStimulus();
    end
    check("full_cnt", outstanding, 5'd4);
    sRdv = 1'b1; sRdata = 32'hA5A5_0001; applyStimulus();
    check("full_gnt_blocked", obi.core_gnt_o, 1'b0);
    idle(); sReq = 1'b1; applyStimulus();
    check("full_gnt_after", obi.core_gnt_o, 1'b1);
    drain();

    // Waitrequest stall: no grant, command held steady.
    sReq = 1'b1; sWe = 1'b1; sAddr = 32'h300; sWdata = 32'h1122_3344; sBe = 4'h3;
    for (int i = 0; i < 3; i++) begin
      sWait = 1'b1; applyStimulus();
      check("wait_gnt",  obi.core_gnt_o,    1'b0);
      check("wait_addr", avm.avm_address_o, 32'h300);
      check("wait_wr",   avm.avm_write_o,   1'b1);
    end
    sWait = 1'b0; applyStimulus();
    check("wait_release_gnt", obi.core_gnt_o, 1'b1);
    sBe = 4'hF;
    drain();

    // Ordering: a write issued behind a slow read retires right after it.
    idle(); sReq = 1'b1; sWe = 1'b0; sAddr = 32'h400; applyStimulus();
    sWe = 1'b1; sAddr = 32'h404; applyStimulus();
    idle(); applyStimulus(); applyStimulus(); applyStimulus();
    sRdv = 1'b1; sRdata = 32'h1234_5678; applyStimulus();
    idle(); applyStimulus();
`ifndef OBI_AVL_WRESP_EN
    check("order_read_rvalid", obi.core_rvalid_o, 1'b1);
    check("order_read_rdata",  obi.core_rdata_o,  32'h1234_5678);
    applyStimulus();
    check("order_write_rvalid", obi.core_rvalid_o, 1'b1);
    check("order_write_rdata",  obi.core_rdata_o,  32'h0);
`endif
    drain();

    // Error response, then a stray response with nothing outstanding.
    idle(); sReq = 1'b1; sAddr = 32'h500; applyStimulus();
    idle(); sRdv = 1'b1; sResp = 2'b10; sRdata = 32'hCAFE_0000; applyStimulus();
    idle(); applyStimulus();
    check("err_flag", obi.core_err_o, 1'b1);
    sRdv = 1'b1; applyStimulus();
    idle(); applyStimulus();
    check("stray_rvalid", obi.core_rvalid_o, 1'b0);
    check("stray_proto",  protoErr,          1'b1);
    applyStimulus(); applyStimulus();
    pulseReset();
    check("proto_cleared", protoErr, 1'b0);

    // Reset mid-flight discards transfers; a late response is a protocol error.
    idle(); sReq = 1'b1; sAddr = 32'h600; applyStimulus(); applyStimulus();
    idle(); sRst = 1'b1; applyStimulus();
    sRst = 1'b0; applyStimulus();
    sRdv = 1'b1; applyStimulus();
    idle(); applyStimulus();
    check("late_resp_proto", protoErr, 1'b1);
    pulseReset();

    // Random traffic with legal responses.
    for (int i = 0; i < 400; i++) begin
      sReq   = ($urandom_range(0, 9) < 7);
      sWe    = 1'($urandom_range(0, 1));
      sAddr  = $urandom;
      sBe    = 4'($urandom);
      sWdata = $urandom;
      sWait  = ($urandom_range(0, 3) == 0);
      sRdata = $urandom;
      sResp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sRdv   = (mq.size() > 0) && (mq[0] == 1'b0) && ($urandom_range(0, 1) == 1);
`ifdef OBI_AVL_WRESP_EN
      sWrv   = (mq.size() > 0) && (mq[0] == 1'b1) && ($urandom_range(0, 1) == 1);
`else
      sWrv   = 1'($urandom_range(0, 1));
`endif
      applyStimulus();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
